// File: rtl/if_fetch_queue_pkg.sv
// Shared types for the fetch queue: bus widths, PC step and the queued entry.
package if_fetch_queue_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    typedef logic [INST_W-1:0] inst_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t PC_INC = 32'd4;

    typedef struct packed {
        addr_t pc;
        inst_t inst;
    } fetch_t;

    function automatic addr_t align_pc(input addr_t a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_queue_inst_fifo.sv
// Synchronous FIFO of {pc, inst} entries; head holds its last value when empty.
module inst_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_t                 din,
    input  logic                   pop,
    input  logic                   clear,
    output fetch_t                 head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_t         mem [DEPTH];
    fetch_t         hold;
    logic [AW-1:0]  wr;
    logic [AW-1:0]  rd;

    assign head = (count != '0) ? mem[rd] : hold;

    always_ff @(posedge clk) begin
        if (push && !rst && !clear) begin
            mem[wr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
            hold  <= '0;
        end else if (clear) begin
            // Remember what was presented so the output does not jump.
            wr    <= '0;
            rd    <= '0;
            count <= '0;
            hold  <= head;
        end else begin
            if (push) begin
                wr <= wr + 1'b1;
            end
            if (pop) begin
                hold <= mem[rd];
                rd   <= rd + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: owns the PC, drives the 1-cycle ROM, queues {pc, inst} for IF_ID.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter addr_t RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_ce_o,
    output addr_t                  rom_addr_o,
    input  inst_t                  rom_data_i,
    input  logic                   redirect_i,
    input  addr_t                  redirect_pc_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output addr_t                  id_pc_o,
    output inst_t                  id_inst_o,
    output logic [$clog2(DEPTH):0] occupancy_o
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    addr_t          pc;
    addr_t          req_pc;
    logic           inflight;
    logic [CW-1:0]  count;
    logic [CW:0]    used;
    logic           issue;
    logic           push;
    logic           pop;
    fetch_t         din;
    fetch_t         head;

    // Queued plus in-flight entries reserve slots, so a push can never overflow.
    assign used  = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue = !rst && !redirect_i && (used < DEPTH_W);

    assign push = inflight && !redirect_i;
    assign pop  = id_valid_o && id_ready_i;
    assign din  = {req_pc, rom_data_i};

    assign rom_ce_o    = issue;
    assign rom_addr_o  = pc;
    assign id_valid_o  = !rst && (count != '0) && !redirect_i;
    assign id_pc_o     = head.pc;
    assign id_inst_o   = head.inst;
    assign occupancy_o = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (redirect_i) begin
            pc       <= align_pc(redirect_pc_i);
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc     <= pc + PC_INC;
                req_pc <= pc;
            end
        end
    end

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .clear (redirect_i),
        .head  (head),
        .count (count)
    );

endmodule
